sprite_cfg_loader: RTL and testbench

- SPI-mode-0 slave that receives sprite configuration (position, colours, 1-bpp bitmap) over the ui_in pins.
- Stages the configuration in shadow registers and commits it to the active registers only at frame start, so the renderer never shows a torn sprite.
- Sits between the top-level tt_um pin wrapper and the sprite renderer / VGA pixel mux.

---
 rtl/sprite_cfg_pkg.sv | 26 ++
 rtl/sprite_cfg_loader_spi_byte_rx.sv | 52 +++++
 rtl/sprite_cfg_loader.sv | 159 +++++++++++++++
 tb/tb_sprite_cfg_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cfg_pkg.sv
// Shared types and constants for the sprite configuration loader.
package sprite_cfg_pkg;

  localparam logic [7:0] CMD_X   = 8'h01;
  localparam logic [7:0] CMD_Y   = 8'h02;
  localparam logic [7:0] CMD_COL = 8'h03;
  localparam logic [7:0] CMD_BMP = 8'h04;

  localparam int XY_BYTES  = 2;
  localparam int COL_BYTES = 2;
  localparam int NUM_GRPS  = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_SKIP} state_t;

  // Group index doubles as the bit position in the pending-flag vector.
  typedef enum logic [1:0] {GRP_X, GRP_Y, GRP_COL, GRP_BMP} grp_t;

  function automatic int grp_bytes(input grp_t g, input int bmp_bytes);
    case (g)
      GRP_X, GRP_Y: return XY_BYTES;
      GRP_COL:      return COL_BYTES;
      default:      return bmp_bytes;
    endcase
  endfunction

endpackage

// File: rtl/sprite_cfg_loader_spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronisers, sclk edge detect and shift register.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       cs_active,
  output logic       cs_rise
);

  logic [1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_prev, cs_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       sclk_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= 2'b11;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
      if (cs_sync[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {shift[5:0], mosi_sync[1]};
      end
    end
  end

  // Byte strobe is combinational off the detected edge so the caller writes on the 3rd clk.
  assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
  assign byte_valid = sclk_rise & ~cs_sync[1] & (bit_cnt == 3'd7);
  assign byte_data  = {shift, mosi_sync[1]};
  assign cs_active  = ~cs_sync[1];
  assign cs_rise    = cs_sync[1] & ~cs_prev;

endmodule

// File: rtl/sprite_cfg_loader.sv
// Sprite config loader: SPI writes land in shadow registers, committed to active at frame start.
module sprite_cfg_loader
  import sprite_cfg_pkg::*;
#(
  parameter int SPRITE_W = 12,
  parameter int SPRITE_H = 12,
  parameter int POS_W    = 10,
  parameter logic [SPRITE_W*SPRITE_H-1:0] DEFAULT_BITMAP = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_sclk,
  input  logic                         spi_mosi,
  input  logic                         spi_cs_n,
  input  logic                         frame_start,
  output logic [POS_W-1:0]             sprite_x_o,
  output logic [POS_W-1:0]             sprite_y_o,
  output logic [5:0]                   color_bg_o,
  output logic [5:0]                   color_fg_o,
  output logic [SPRITE_W*SPRITE_H-1:0] bitmap_o,
  output logic                         cfg_pending_o,
  output logic                         cfg_updated_o
);

  localparam int BMP_BITS  = SPRITE_W * SPRITE_H;
  localparam int BMP_BYTES = BMP_BITS / 8;
  localparam int IDX_W     = $clog2(BMP_BYTES + 1);
  localparam int BMP_IDX_W = $clog2(BMP_BITS);

  logic             byte_valid, cs_active, cs_rise;
  logic [7:0]       byte_data;

  spi_byte_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .cs_active  (cs_active),
    .cs_rise    (cs_rise)
  );

  state_t                state, state_d;
  grp_t                  grp, cmd_grp;
  logic                  cmd_ok, grp_done, data_last, wr_en;
  logic [IDX_W-1:0]      byte_idx;
  logic [BMP_IDX_W-1:0]  bmp_msb;
  logic [NUM_GRPS-1:0]   pending, set_mask, commit;

  logic [POS_W-1:0]      sh_x, sh_y, act_x, act_y;
  logic [5:0]            sh_bg, sh_fg, act_bg, act_fg;
  logic [BMP_BITS-1:0]   sh_bmp, act_bmp;
  logic                  updated;

  always_comb begin
    cmd_ok  = 1'b1;
    cmd_grp = GRP_X;
    case (byte_data)
      CMD_X:   cmd_grp = GRP_X;
      CMD_Y:   cmd_grp = GRP_Y;
      CMD_COL: cmd_grp = GRP_COL;
      CMD_BMP: cmd_grp = GRP_BMP;
      default: cmd_ok  = 1'b0;
    endcase
  end

  assign data_last = (int'(byte_idx) == grp_bytes(grp, BMP_BYTES) - 1);
  assign bmp_msb   = BMP_IDX_W'(BMP_BITS - 1 - 8 * int'(byte_idx));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    wr_en    = 1'b0;
    set_mask = '0;
    if (!cs_active) begin
      state_d = ST_IDLE;
      if (cs_rise && grp_done) set_mask[grp] = 1'b1;
    end else begin
      case (state)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD:  if (byte_valid) state_d = cmd_ok ? ST_DATA : ST_SKIP;
        ST_DATA: if (byte_valid) begin
                   wr_en = 1'b1;
                   if (data_last) state_d = ST_SKIP;
                 end
        default: ;
      endcase
    end
  end

  // Commit uses the flags held before this edge; a flag set on the same edge waits a frame.
  assign commit = frame_start ? pending : '0;

  // NOTE: the wide shadow/active bitmaps are plain registers, not a memory, and take a reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp      <= GRP_X;
      byte_idx <= '0;
      grp_done <= 1'b0;
      pending  <= '0;
      updated  <= 1'b0;
      sh_x     <= '0;
      sh_y     <= '0;
      sh_bg    <= 6'h00;
      sh_fg    <= 6'h3F;
      sh_bmp   <= DEFAULT_BITMAP;
      act_x    <= '0;
      act_y    <= '0;
      act_bg   <= 6'h00;
      act_fg   <= 6'h3F;
      act_bmp  <= DEFAULT_BITMAP;
    end else begin
      if (state == ST_CMD && cs_active && byte_valid) begin
        grp      <= cmd_grp;
        byte_idx <= '0;
      end
      if (wr_en) begin
        byte_idx <= byte_idx + IDX_W'(1);
        if (data_last) grp_done <= 1'b1;
        case (grp)
          GRP_X:   if (byte_idx == '0) sh_x[POS_W-1:8] <= byte_data[POS_W-9:0];
                   else                sh_x[7:0]       <= byte_data;
          GRP_Y:   if (byte_idx == '0) sh_y[POS_W-1:8] <= byte_data[POS_W-9:0];
                   else                sh_y[7:0]       <= byte_data;
          GRP_COL: if (byte_idx == '0) sh_bg <= byte_data[5:0];
                   else                sh_fg <= byte_data[5:0];
          default: sh_bmp[bmp_msb -: 8] <= byte_data;
        endcase
      end
      if (state_d == ST_IDLE) grp_done <= 1'b0;

      pending <= (pending & ~commit) | set_mask;
      updated <= |commit;
      if (commit[GRP_X])   act_x   <= sh_x;
      if (commit[GRP_Y])   act_y   <= sh_y;
      if (commit[GRP_COL]) begin
        act_bg <= sh_bg;
        act_fg <= sh_fg;
      end
      if (commit[GRP_BMP]) act_bmp <= sh_bmp;
    end
  end

  assign sprite_x_o    = act_x;
  assign sprite_y_o    = act_y;
  assign color_bg_o    = act_bg;
  assign color_fg_o    = act_fg;
  assign bitmap_o      = act_bmp;
  assign cfg_pending_o = |pending;
  assign cfg_updated_o = updated;

endmodule

// File: tb/tb_sprite_cfg_loader.sv
// Scoreboard bench for sprite_cfg_loader: directed SPI transactions, commits checked on cfg_updated_o.
module tb_sprite_cfg_loader;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, frame_start = 1'b0;
  logic [9:0]   sprite_x_o, sprite_y_o;
  logic [5:0]   color_bg_o, color_fg_o;
  logic [143:0] bitmap_o;
  logic         cfg_pending_o, cfg_updated_o;

  sprite_cfg_loader #(
    .SPRITE_W(12), .SPRITE_H(12), .POS_W(10), .DEFAULT_BITMAP(144'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_cs_n      (spi_cs_n),
    .frame_start   (frame_start),
    .sprite_x_o    (sprite_x_o),
    .sprite_y_o    (sprite_y_o),
    .color_bg_o    (color_bg_o),
    .color_fg_o    (color_fg_o),
    .bitmap_o      (bitmap_o),
    .cfg_pending_o (cfg_pending_o),
    .cfg_updated_o (cfg_updated_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]   x;
    logic [9:0]   y;
    logic [5:0]   bg;
    logic [5:0]   fg;
    logic [143:0] bmp;
  } cfg_t;

  localparam cfg_t RST_CFG = '{x: 10'd0, y: 10'd0, bg: 6'h00, fg: 6'h3F, bmp: 144'h0};

  cfg_t       exp_q[$];
  cfg_t       model;
  cfg_t       mon_e;
  logic [7:0] tx_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cfg(input string tag, input cfg_t e);
    check({tag, "_x"},   144'(sprite_x_o), 144'(e.x));
    check({tag, "_y"},   144'(sprite_y_o), 144'(e.y));
    check({tag, "_bg"},  144'(color_bg_o), 144'(e.bg));
    check({tag, "_fg"},  144'(color_fg_o), 144'(e.fg));
    check({tag, "_bmp"}, bitmap_o, e.bmp);
  endtask

  // Monitor: every update pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && cfg_updated_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update", 144'(1), 144'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_cfg("commit", mon_e);
      end
    end
  end

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      repeat (5) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  // Sends tx_q as one chip-select frame; returns on the negedge where cs_n goes high.
  task automatic xfer();
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    while (tx_q.size() > 0) spi_byte(tx_q.pop_front());
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
  endtask

  task automatic settle_pending(input string tag, input logic exp);
    repeat (4) @(negedge clk);
    check(tag, 144'(cfg_pending_o), 144'(exp));
  endtask

  task automatic commit_frame(input string tag);
    exp_q.push_back(model);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk);
    check({tag, "_update_seen"}, 144'(exp_q.size()), 144'(0));
    check({tag, "_pulse_width"}, 144'(cfg_updated_o), 144'(0));
    check({tag, "_pend_clr"}, 144'(cfg_pending_o), 144'(0));
  endtask

  task automatic idle_frame(input string tag);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check({tag, "_no_update"}, 144'(cfg_updated_o), 144'(0));
    @(negedge clk);
    check_cfg(tag, model);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    model = RST_CFG;
    repeat (2) @(negedge clk);
    check_cfg("rst", model);
    check("rst_pending", 144'(cfg_pending_o), 144'(0));
    check("rst_updated", 144'(cfg_updated_o), 144'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // X = 0x140 = 320; pending rises on the 3rd clk after cs_n rises
    tx_q = '{8'h01, 8'h01, 8'h40};
    xfer();
    @(posedge clk); @(posedge clk); #1;
    check("x_pend_early", 144'(cfg_pending_o), 144'(0));
    @(posedge clk); #1;
    check("x_pend_set", 144'(cfg_pending_o), 144'(1));
    check("x_not_yet", 144'(sprite_x_o), 144'(0));
    model.x = 10'd320;
    commit_frame("x");

    // Bitmap of 0xA5 and colours in two frames, both committed on one frame_start
    tx_q = '{8'h04};
    for (int i = 0; i < 18; i++) tx_q.push_back(8'hA5);
    xfer();
    tx_q = '{8'h03, 8'hC1, 8'h3F};
    xfer();
    settle_pending("bmpcol_pend", 1'b1);
    model.bmp = {18{8'hA5}};
    model.bg  = 6'h01;
    model.fg  = 6'h3F;
    commit_frame("bmpcol");

    // Aborted Y write: nothing pending, frame leaves outputs alone
    tx_q = '{8'h02, 8'h00};
    xfer();
    settle_pending("abort_pend", 1'b0);
    idle_frame("abort");
    tx_q = '{8'h02, 8'h00, 8'h64};
    xfer();
    settle_pending("y_pend", 1'b1);
    model.y = 10'd100;
    commit_frame("y");

    // Unknown command, then X with trailing extra bytes
    tx_q = '{8'h7F, 8'h12};
    xfer();
    settle_pending("unk_pend", 1'b0);
    idle_frame("unk");
    tx_q = '{8'h01, 8'h00, 8'h10, 8'hFF, 8'hFF};
    xfer();
    settle_pending("xextra_pend", 1'b1);
    model.x = 10'd16;
    commit_frame("xextra");

    // Pending flag set on the same edge as frame_start: deferred one frame
    tx_q = '{8'h01, 8'h02, 8'h03};
    xfer();
    @(negedge clk);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("race_no_update", 144'(cfg_updated_o), 144'(0));
    check("race_pend_kept", 144'(cfg_pending_o), 144'(1));
    check("race_x_held", 144'(sprite_x_o), 144'(16));
    model.x = 10'd515;
    commit_frame("race");

    // Reset in the middle of a bitmap transfer
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h04);
    for (int i = 0; i < 5; i++) spi_byte(8'hFF);
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (2) @(negedge clk);
    model = RST_CFG;
    check_cfg("midrst", model);
    check("midrst_pending", 144'(cfg_pending_o), 144'(0));
    rst_n = 1'b1;
    settle_pending("postrst_pend", 1'b0);
    idle_frame("postrst");

    repeat (4) @(negedge clk);
    check("queue_drain", 144'(exp_q.size()), 144'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
